// File: rtl/alu_frame_pkg.sv
// alu_frame_pkg: shared definitions for the framed ALU controller.
//   state_t          - controller state encoding
//   STATUS_OK/BADCHK - reply status byte values
//   nb_bytes()       - operand width in bytes (NB_REG / NB_DATA)
//   bcnt_w()         - byte-counter width, never narrower than one bit
package alu_frame_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_OP,
    ST_RA,
    ST_RB,
    ST_CHK,
    ST_EXEC,
    ST_SEND_HDR,
    ST_SEND_STAT,
    ST_SEND_RES,
    ST_SEND_CHK
  } state_t;

  localparam logic [7:0] STATUS_OK     = 8'h00;
  localparam logic [7:0] STATUS_BADCHK = 8'h01;

  function automatic int nb_bytes(input int nb_reg, input int nb_data);
    return nb_reg / nb_data;
  endfunction

  // A single-byte operand still needs a 1-bit counter to keep vectors legal.
  function automatic int bcnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_frame_ctrl_timeout.sv
// frame_timeout: inter-byte watchdog for frame reception.
//   clk     - clock
//   rst_n   - synchronous reset, active low
//   clear   - zero the counter (byte popped, or not inside a frame)
//   enable  - count this cycle (inside a frame and RX empty)
//   expire  - counter has reached TIMEOUT_CYC-1 while enabled
module frame_timeout #(
  parameter int NB_TIMEOUT  = 16,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [NB_TIMEOUT-1:0] LIMIT = NB_TIMEOUT'(TIMEOUT_CYC - 1);

  logic [NB_TIMEOUT-1:0] cnt;

  assign expire = enable && (cnt == LIMIT);

  // Once expired the controller leaves the frame states, which clears us;
  // holding at LIMIT avoids wrapping if that ever takes an extra cycle.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) cnt <= '0;
    else if (enable && !expire) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/alu_frame_ctrl.sv
// alu_frame_ctrl: framed protocol controller between RX FIFO, ALU and TX FIFO.
// Request : HDR, OP, A[LSB..MSB], B[LSB..MSB], CHK (XOR of OP and operand bytes)
// Reply   : HDR, STATUS, RESULT[LSB..MSB], CHK (XOR of STATUS and result bytes)
// Ports:
//   clk, i_rst (sync, active low)
//   i_rx_data/i_rx_empty/o_rd    - first-word-fall-through RX FIFO
//   o_tx_data/o_wr/i_tx_full     - TX FIFO
//   o_alu_a/o_alu_b/o_alu_op     - registered ALU operands, i_alu_out result
//   o_frame_ok                   - pulse when a good frame is executed
//   o_err_cnt                    - saturating checksum + timeout error count
module alu_frame_ctrl
  import alu_frame_pkg::*;
#(
  parameter int                 NB_DATA     = 8,
  parameter int                 NB_REG      = 32,
  parameter int                 NB_OP       = 6,
  parameter logic [NB_DATA-1:0] HDR         = 8'hA5,
  parameter int                 NB_TIMEOUT  = 16,
  parameter int                 TIMEOUT_CYC = 50000,
  parameter int                 NB_ERRCNT   = 8
) (
  input  logic                 clk,
  input  logic                 i_rst,
  input  logic [NB_DATA-1:0]   i_rx_data,
  input  logic                 i_rx_empty,
  output logic                 o_rd,
  output logic [NB_DATA-1:0]   o_tx_data,
  output logic                 o_wr,
  input  logic                 i_tx_full,
  output logic [NB_REG-1:0]    o_alu_a,
  output logic [NB_REG-1:0]    o_alu_b,
  output logic [NB_OP-1:0]     o_alu_op,
  input  logic [NB_REG-1:0]    i_alu_out,
  output logic                 o_frame_ok,
  output logic [NB_ERRCNT-1:0] o_err_cnt
);

  localparam int                 NB_BYTES  = nb_bytes(NB_REG, NB_DATA);
  localparam int                 NB_BCNT   = bcnt_w(NB_BYTES);
  localparam logic [NB_BCNT-1:0] LAST_BYTE = NB_BCNT'(NB_BYTES - 1);

  state_t               state, nxt;
  logic [NB_BCNT-1:0]   bcnt;
  logic [NB_DATA-1:0]   rx_xor, tx_xor, status, res_byte, tx;
  logic [NB_REG-1:0]    result;
  logic                 rd, wr, ok, in_frame, chk_match, tmo_expire, err_inc;

  assign in_frame  = state inside {ST_OP, ST_RA, ST_RB, ST_CHK};
  assign chk_match = (i_rx_data == rx_xor);
  assign res_byte  = result[int'(bcnt)*NB_DATA +: NB_DATA];
  assign err_inc   = (state == ST_CHK && rd && !chk_match) || tmo_expire;

  assign o_rd       = rd;
  assign o_wr       = wr;
  assign o_tx_data  = tx;
  assign o_frame_ok = ok;

  frame_timeout #(
    .NB_TIMEOUT (NB_TIMEOUT),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk   (clk),
    .rst_n (i_rst),
    .clear (!in_frame || rd),
    .enable(in_frame && i_rx_empty),
    .expire(tmo_expire)
  );

  always_ff @(posedge clk) begin
    if (!i_rst) state <= ST_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    rd  = 1'b0;
    wr  = 1'b0;
    tx  = '0;
    ok  = 1'b0;
    case (state)
      ST_IDLE: begin
        rd = !i_rx_empty;
        if (rd && i_rx_data == HDR) nxt = ST_OP;
      end
      ST_OP: begin
        rd = !i_rx_empty;
        if (rd) nxt = ST_RA;
      end
      ST_RA: begin
        rd = !i_rx_empty;
        if (rd && bcnt == LAST_BYTE) nxt = ST_RB;
      end
      ST_RB: begin
        rd = !i_rx_empty;
        if (rd && bcnt == LAST_BYTE) nxt = ST_CHK;
      end
      ST_CHK: begin
        rd = !i_rx_empty;
        if (rd) nxt = chk_match ? ST_EXEC : ST_SEND_HDR;
      end
      ST_EXEC: begin
        ok  = 1'b1;
        nxt = ST_SEND_HDR;
      end
      ST_SEND_HDR: begin
        tx = HDR;
        wr = !i_tx_full;
        if (wr) nxt = ST_SEND_STAT;
      end
      ST_SEND_STAT: begin
        tx = status;
        wr = !i_tx_full;
        if (wr) nxt = ST_SEND_RES;
      end
      ST_SEND_RES: begin
        tx = res_byte;
        wr = !i_tx_full;
        if (wr && bcnt == LAST_BYTE) nxt = ST_SEND_CHK;
      end
      ST_SEND_CHK: begin
        tx = tx_xor;
        wr = !i_tx_full;
        if (wr) nxt = ST_IDLE;
      end
      default: nxt = ST_IDLE;
    endcase
    // Stalled frame: drop it silently, no reply.
    if (tmo_expire) nxt = ST_IDLE;
    // Keep FIFOs untouched while reset is held so nothing is popped or
    // half-written across the reset edge.
    if (!i_rst) begin
      rd = 1'b0;
      wr = 1'b0;
      tx = '0;
      ok = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!i_rst) begin
      bcnt      <= '0;
      rx_xor    <= '0;
      tx_xor    <= '0;
      status    <= '0;
      result    <= '0;
      o_alu_a   <= '0;
      o_alu_b   <= '0;
      o_alu_op  <= '0;
      o_err_cnt <= '0;
    end else begin
      if (err_inc && o_err_cnt != '1) o_err_cnt <= o_err_cnt + 1'b1;
      case (state)
        ST_OP: if (rd) begin
          // Upper opcode bits are dropped but still count toward the checksum.
          o_alu_op <= i_rx_data[NB_OP-1:0];
          rx_xor   <= i_rx_data;
          bcnt     <= '0;
        end
        ST_RA: if (rd) begin
          o_alu_a[int'(bcnt)*NB_DATA +: NB_DATA] <= i_rx_data;
          rx_xor <= rx_xor ^ i_rx_data;
          bcnt   <= (bcnt == LAST_BYTE) ? '0 : bcnt + 1'b1;
        end
        ST_RB: if (rd) begin
          o_alu_b[int'(bcnt)*NB_DATA +: NB_DATA] <= i_rx_data;
          rx_xor <= rx_xor ^ i_rx_data;
          bcnt   <= (bcnt == LAST_BYTE) ? '0 : bcnt + 1'b1;
        end
        ST_CHK: if (rd) begin
          status <= chk_match ? NB_DATA'(STATUS_OK) : NB_DATA'(STATUS_BADCHK);
          if (!chk_match) result <= '0;
        end
        // Operands were registered on the previous pops, so the ALU output
        // is already settled here.
        ST_EXEC: result <= i_alu_out;
        ST_SEND_HDR: if (wr) begin
          tx_xor <= '0;
          bcnt   <= '0;
        end
        ST_SEND_STAT: if (wr) tx_xor <= status;
        ST_SEND_RES: if (wr) begin
          tx_xor <= tx_xor ^ res_byte;
          bcnt   <= (bcnt == LAST_BYTE) ? '0 : bcnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu_frame_ctrl.md
Name: alu_frame_ctrl

Overview:
- Parametrised framed-protocol controller between the RX FIFO, the ALU and the TX FIFO. It supersedes the fixed single-byte interface FSM.
- Assembles multi-byte operands of any NB_REG that is a multiple of NB_DATA, and validates header and checksum.
- Aborts stalled frames on an inter-byte timeout.
- Returns a status-tagged, checksummed result frame.

Parameters:
- NB_DATA, 8: UART byte width.
- NB_REG, 32: ALU operand/result width; must be a multiple of NB_DATA.
- NB_OP, 6: ALU op width; must be <= NB_DATA.
- HDR, 8'hA5: frame header byte.
- NB_TIMEOUT, 16: timeout counter width.
- TIMEOUT_CYC, 50000: max clk cycles between consecutive bytes inside a frame.
- NB_ERRCNT, 8: error counter width.

Ports:
- clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-low
- i_rx_data  in  NB_DATA  RX FIFO head word (first-word-fall-through)
- i_rx_empty  in  1  RX FIFO empty
- o_rd  out  1  RX FIFO pop strobe
- o_tx_data  out  NB_DATA  TX FIFO write data
- o_wr  out  1  TX FIFO write strobe
- i_tx_full  in  1  TX FIFO full
- o_alu_a  out  NB_REG  ALU operand A
- o_alu_b  out  NB_REG  ALU operand B
- o_alu_op  out  NB_OP  ALU opcode
- i_alu_out  in  NB_REG  ALU result (combinational from o_alu_*)
- o_frame_ok  out  1  one-cycle pulse when a good frame is queued for reply
- o_err_cnt  out  NB_ERRCNT  saturating count of checksum and timeout errors

Behaviour:
- One clock, clk. Reset is synchronous, active-low on i_rst.
- Reset values (i_rst==0 at a clk edge): all outputs 0, state IDLE, counters 0. Reset mid-frame discards the frame; no partial write occurs after the reset edge.
- Frame in: HDR, OP, A bytes LSB first (NB_REG/NB_DATA bytes), B bytes LSB first, CHK.
- CHK = XOR of OP and all A/B bytes.
- Frame out: HDR, STATUS, RESULT bytes LSB first, CHK.
  - Out CHK = XOR of STATUS and all RESULT bytes.
  - STATUS: 8'h00 for ok, 8'h01 for bad checksum; on bad checksum RESULT is all zeros.
- Byte consumption: a byte is consumed in the cycle where o_rd=1, only when i_rx_empty=0. Data is sampled from i_rx_data in that same cycle. At most one pop per cycle.
- States:
  - IDLE: pop bytes; a non-HDR byte is dropped silently and the state stays IDLE; HDR -> OP.
  - OP: store i_rx_data[NB_OP-1:0]; upper bits are ignored but included in CHK -> RA.
  - RA: fill A byte by byte, byte counter 0..NB_REG/NB_DATA-1; last byte -> RB.
  - RB: same for B -> CHK.
  - CHK: compare against the running XOR. Match -> EXEC. Mismatch -> err_cnt++ and go to SEND_HDR with status 01.
  - EXEC: one cycle; o_alu_* are already registered, so capture i_alu_out into the result register and pulse o_frame_ok -> SEND_HDR.
  - SEND_HDR, SEND_STAT, SEND_RES (per byte), SEND_CHK: each writes one byte with o_wr=1 only when i_tx_full=0; otherwise hold the state and the byte. SEND_CHK -> IDLE.
- No RX pops occur while in any SEND state; RX bytes stay buffered in the FIFO.
- Timeout:
  - Counter runs in OP/RA/RB/CHK while i_rx_empty=1; it resets to 0 on every pop.
  - On reaching TIMEOUT_CYC-1: err_cnt++, return to IDLE, discard the partial frame, send no reply.
  - The counter is idle in IDLE and SEND states.
- err_cnt saturates at all-ones.
- o_alu_a/b/op hold their last values until the next frame overwrites them byte by byte.
- Latency: good frame, CHK byte popped at cycle t:
  - EXEC at t+1.
  - HDR written at t+2 if TX is not full.
  - Last CHK byte written at t+2+NB_REG/NB_DATA+2 with no backpressure.

Decomposition:
- Shared package alu_frame_pkg holds:
  - state encoding localparams;
  - STATUS_OK / STATUS_BADCHK;
  - the NB_BYTES = NB_REG/NB_DATA derivation;
  - the byte-counter width clog2(NB_BYTES).
- One natural sub-module: frame_timeout, the inter-byte timeout counter with clear/enable inputs and an expire output. Everything else stays in one FSM file.

Test Plan:
1. Good add frame, NB_REG=32: A5 20 01 00 00 00 02 00 00 00 23, with the ALU model returning A+B=3 -> o_frame_ok pulse; TX bytes A5 00 03 00 00 00 03; err_cnt=0.
2. Bad checksum: same frame but CHK=24 -> TX A5 01 00 00 00 00 01; err_cnt=1; no o_frame_ok.
3. Junk before header: 00 FF 5A then the frame from test 1 -> junk dropped; reply identical to test 1; err_cnt unchanged.
4. Timeout: A5 20 01, then RX stays empty for TIMEOUT_CYC cycles -> state IDLE, err_cnt+1, no o_wr. A following valid frame is answered correctly.
5. TX backpressure: hold i_tx_full=1 for 20 cycles mid-reply -> no o_wr while full; all 7 bytes arrive in order with none lost or duplicated.
6. Reset mid-RB (i_rst=0 for one cycle) -> all outputs 0, err_cnt 0. Next frame with NB_REG=16 (A5 03 FF 00 01 00 FD) is parsed as 2-byte operands.
